// File: rtl/pc_stack_unit.sv
// pc_stack_unit
//
// Program-counter sequencer with a hardware subroutine return stack. It feeds
// the instruction-memory address of the single-cycle cpu datapath, choosing
// each cycle between sequential fetch, absolute jump, call (push return
// address) and return (pop).
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   halt         freeze pc and stack for this cycle (overrides everything but reset)
//   jmp          load target into pc
//   call         push pc+1, then load target into pc
//   ret          pop top of stack into pc
//   target       absolute destination for jmp/call
//   pc           registered instruction address
//   stack_empty  stack holds no entries
//   stack_full   stack holds DEPTH entries
//   stack_err    sticky overflow/underflow flag, cleared only by reset
//   depth        current number of stack entries
//
// Action priority on every edge: reset > halt > ret > call > jmp > sequential.
// All outputs come straight from registers; there is no input-to-output path.

module pc_stack_unit #(
  parameter int AW    = 10,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     halt,
  input  logic                     jmp,
  input  logic                     call,
  input  logic                     ret,
  input  logic [AW-1:0]            target,
  output logic [AW-1:0]            pc,
  output logic                     stack_empty,
  output logic                     stack_full,
  output logic                     stack_err,
  output logic [$clog2(DEPTH):0]   depth
);

  localparam int SPW = $clog2(DEPTH) + 1;
  localparam int IW  = SPW - 1;
  localparam logic [SPW-1:0] SP_ZERO = '0;
  localparam logic [SPW-1:0] SP_ONE  = SPW'(1);
  localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

  // Occupancy class of the stack; steers push/pop legality.
  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_PARTIAL = 2'd1,
    S_FULL    = 2'd2
  } occ_t;

  occ_t            state_q, state_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic [AW-1:0]   ra;
  logic [SPW-1:0]  sp_q, sp_d;
  logic            err_q, err_d;
  logic            push_en;
  logic [IW-1:0]   push_idx;
  logic [IW-1:0]   pop_idx;
  logic [AW-1:0]   stk [DEPTH];

  // Return address wraps naturally at 2^AW.
  assign ra       = pc_q + AW'(1);
  // push_idx is only used when sp < DEPTH, so dropping the MSB is safe.
  assign push_idx = sp_q[IW-1:0];
  // pop reads the entry below the pre-edge sp; only used when sp > 0.
  assign pop_idx  = IW'(sp_q - SP_ONE);

  // Next-state / action decode.
  always_comb begin
    pc_d    = ra;
    sp_d    = sp_q;
    err_d   = err_q;
    push_en = 1'b0;
    state_d = state_q;

    if (halt) begin
      pc_d = pc_q;
    end else if (ret) begin
      if (state_q != S_EMPTY) begin
        pc_d = stk[pop_idx];
        sp_d = sp_q - SP_ONE;
      end else begin
        // Underflow: fall through to the next sequential address.
        err_d = 1'b1;
      end
    end else if (call) begin
      pc_d = target;
      if (state_q != S_FULL) begin
        push_en = 1'b1;
        sp_d    = sp_q + SP_ONE;
      end else begin
        // Overflow: the jump still happens, the return address is lost.
        err_d = 1'b1;
      end
    end else if (jmp) begin
      pc_d = target;
    end

    if (sp_d == SP_ZERO) begin
      state_d = S_EMPTY;
    end else if (sp_d == SP_FULL) begin
      state_d = S_FULL;
    end else begin
      state_d = S_PARTIAL;
    end
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= '0;
      sp_q    <= '0;
      err_q   <= 1'b0;
      state_q <= S_EMPTY;
    end else begin
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      err_q   <= err_d;
      state_q <= state_d;
    end
  end

  // Stack storage carries no reset; entries above sp are never read.
  always_ff @(posedge clk) begin
    if (!reset && push_en) begin
      stk[push_idx] <= ra;
    end
  end

  assign pc          = pc_q;
  assign stack_empty = (sp_q == SP_ZERO);
  assign stack_full  = (sp_q == SP_FULL);
  assign stack_err   = err_q;
  assign depth       = sp_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
module tb_pc_stack_unit;

  localparam int AW    = 10;
  localparam int DEPTH = 8;
  localparam int PCMOD = 1 << AW;

  logic              clk;
  logic              reset, halt, jmp, call, ret;
  logic [AW-1:0]     target;
  logic [AW-1:0]     pc;
  logic              stack_empty, stack_full, stack_err;
  logic [$clog2(DEPTH):0] depth;

  int n_checks = 0;
  int n_fail   = 0;

  pc_stack_unit #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .halt        (halt),
    .jmp         (jmp),
    .call        (call),
    .ret         (ret),
    .target      (target),
    .pc          (pc),
    .stack_empty (stack_empty),
    .stack_full  (stack_full),
    .stack_err   (stack_err),
    .depth       (depth)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        r, h, j, c, rt;
    logic [9:0]  t;
    logic [9:0]  pc;
    int          d;
    logic        err;
  } vec_t;

  vec_t tv[$];

  // Reference model state
  int   m_pc;
  int   m_stk[$];
  logic m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input int epc, input int ed, input logic eerr);
    chk({tag, "_pc"},    32'(pc), 32'(epc));
    chk({tag, "_depth"}, 32'(depth), 32'(ed));
    chk({tag, "_empty"}, 32'(stack_empty), 32'(ed == 0));
    chk({tag, "_full"},  32'(stack_full), 32'(ed == DEPTH));
    chk({tag, "_err"},   32'(stack_err), 32'(eerr));
  endtask

  task automatic drive(input logic r, input logic h, input logic j, input logic c,
                       input logic rt, input logic [AW-1:0] t);
    reset = r; halt = h; jmp = j; call = c; ret = rt; target = t;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic r, input logic h, input logic j, input logic c,
                     input logic rt, input logic [9:0] t, input logic [9:0] epc,
                     input int ed, input logic eerr);
    vec_t v;
    v.r = r; v.h = h; v.j = j; v.c = c; v.rt = rt; v.t = t;
    v.pc = epc; v.d = ed; v.err = eerr;
    tv.push_back(v);
  endtask

  // Behavioural model: priority-ordered actions on a queue-backed stack.
  task automatic model_step(input logic r, input logic h, input logic j, input logic c,
                            input logic rt, input int t);
    if (r) begin
      m_pc = 0; m_stk.delete(); m_err = 1'b0;
    end else if (h) begin
      // hold
    end else if (rt) begin
      if (m_stk.size() > 0) m_pc = m_stk.pop_back();
      else begin m_pc = (m_pc + 1) % PCMOD; m_err = 1'b1; end
    end else if (c) begin
      if (m_stk.size() < DEPTH) m_stk.push_back((m_pc + 1) % PCMOD);
      else m_err = 1'b1;
      m_pc = t;
    end else if (j) begin
      m_pc = t;
    end else begin
      m_pc = (m_pc + 1) % PCMOD;
    end
  endtask

  initial begin
    int tgt[DEPTH];
    int exp_ra[DEPTH];
    int cur_pc;

    reset = 1'b0; halt = 1'b0; jmp = 1'b0; call = 1'b0; ret = 1'b0; target = '0;
    @(negedge clk);

    //   r h j c rt target  pc     depth err
    add(1,0,0,0,0, 10'h000, 10'h000, 0, 0);
    add(0,0,0,0,0, 10'h000, 10'h001, 0, 0);
    add(0,0,0,0,0, 10'h000, 10'h002, 0, 0);
    add(0,0,0,0,0, 10'h000, 10'h003, 0, 0);
    add(0,0,0,0,0, 10'h000, 10'h004, 0, 0);
    add(0,0,0,0,0, 10'h000, 10'h005, 0, 0);
    add(1,0,0,0,0, 10'h000, 10'h000, 0, 0);
    add(0,0,0,0,0, 10'h000, 10'h001, 0, 0);
    add(0,0,0,0,0, 10'h000, 10'h002, 0, 0);
    add(0,0,0,0,0, 10'h000, 10'h003, 0, 0);
    add(0,0,0,1,0, 10'h040, 10'h040, 1, 0);
    add(0,0,0,0,0, 10'h000, 10'h041, 1, 0);
    add(0,0,0,0,0, 10'h000, 10'h042, 1, 0);
    add(0,0,0,0,1, 10'h000, 10'h004, 0, 0);
    add(0,0,1,0,0, 10'h010, 10'h010, 0, 0);
    add(0,0,0,0,1, 10'h000, 10'h011, 0, 1);   // underflow
    add(0,0,0,1,0, 10'h050, 10'h050, 1, 1);   // err sticky
    add(0,0,0,0,1, 10'h000, 10'h012, 0, 1);
    add(1,0,0,0,0, 10'h000, 10'h000, 0, 0);
    add(0,0,1,0,0, 10'h007, 10'h007, 0, 0);
    add(0,1,0,1,0, 10'h200, 10'h007, 0, 0);   // halt beats call
    add(0,0,0,1,0, 10'h020, 10'h020, 1, 0);
    add(0,0,1,0,1, 10'h300, 10'h008, 0, 0);   // ret beats jmp
    add(0,0,1,0,0, 10'h3FF, 10'h3FF, 0, 0);
    add(0,0,0,0,0, 10'h000, 10'h000, 0, 0);   // wrap
    add(0,0,1,0,0, 10'h3FF, 10'h3FF, 0, 0);
    add(0,0,0,1,0, 10'h123, 10'h123, 1, 0);   // pushes 0
    add(0,0,0,0,1, 10'h000, 10'h000, 0, 0);

    foreach (tv[i]) begin
      drive(tv[i].r, tv[i].h, tv[i].j, tv[i].c, tv[i].rt, tv[i].t);
      chk_all($sformatf("vec%0d", i), int'(tv[i].pc), tv[i].d, tv[i].err);
    end

    // Nested calls to full, overflow, then LIFO unwind.
    drive(1,0,0,0,0, '0);
    chk_all("nest_rst", 0, 0, 1'b0);
    cur_pc = 0;
    for (int i = 0; i < DEPTH; i++) begin
      tgt[i]    = 10'h080 + i * 4;
      exp_ra[i] = (cur_pc + 1) % PCMOD;
      drive(0,0,0,1,0, AW'(tgt[i]));
      cur_pc = tgt[i];
      chk_all($sformatf("nest_call%0d", i), cur_pc, i + 1, 1'b0);
    end
    drive(0,0,0,1,0, 10'h100);
    chk_all("overflow", 10'h100, DEPTH, 1'b1);
    for (int i = DEPTH - 1; i >= 0; i--) begin
      drive(0,0,0,0,1, '0);
      chk_all($sformatf("nest_ret%0d", i), exp_ra[i], i, 1'b1);
    end

    // Reset in the middle of a subroutine discards the stack.
    drive(1,0,0,0,0, '0);
    drive(0,0,0,1,0, 10'h060);
    drive(0,0,0,1,0, 10'h070);
    chk_all("mid_pre", 10'h070, 2, 1'b0);
    drive(1,0,0,0,0, '0);
    chk_all("mid_rst", 0, 0, 1'b0);
    drive(0,0,0,0,1, '0);
    chk_all("mid_ret", 1, 0, 1'b1);

    // Randomized run against the reference model.
    drive(1,0,0,0,0, '0);
    model_step(1,0,0,0,0, 0);
    for (int n = 0; n < 3000; n++) begin
      logic r, h, j, c, rt;
      int   t;
      r  = ($urandom_range(0, 99) == 0);
      h  = ($urandom_range(0, 7) == 0);
      rt = ($urandom_range(0, 2) == 0);
      c  = ($urandom_range(0, 2) != 0);
      j  = $urandom_range(0, 1) != 0;
      t  = int'($urandom_range(0, PCMOD - 1));
      model_step(r, h, j, c, rt, t);
      drive(r, h, j, c, rt, AW'(t));
      chk_all("rand", m_pc, m_stk.size(), m_err);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_stack_unit.md
# pc_stack_unit

Program-counter and subroutine-return-stack stage that sits directly upstream of the single-cycle `cpu` datapath. Every clock it drives the instruction-memory address. It chooses between sequential fetch, absolute jump, subroutine call (push return address) and subroutine return (pop). Jump targets and branch decisions come from the control unit and datapath. This block owns only the address sequencing and the hardware return stack.

## Interface
Parameters:
- `AW`, 10: width of the program counter and instruction address.
- `DEPTH`, 8: number of return-stack entries. Must be a power of two, at least 2.

Ports:
- `clk`  in  1: rising-edge clock; all state updates on this edge.
- `reset`  in  1: synchronous, active-high reset, sampled on `clk` rising edge.
- `halt`  in  1: freezes the PC and the stack for the cycle.
- `jmp`  in  1: load `target` into the PC.
- `call`  in  1: push the return address, then load `target`.
- `ret`  in  1: pop the top of stack into the PC.
- `target`  in  AW: absolute destination for `jmp` and `call`.
- `pc`  out  AW: current instruction address, registered.
- `stack_empty`  out  1: high when the stack holds 0 entries.
- `stack_full`  out  1: high when the stack holds `DEPTH` entries.
- `stack_err`  out  1: sticky flag for overflow or underflow.
- `depth`  out  clog2(DEPTH)+1: current number of stack entries.

## Operation
- Registered state: `pc`, a stack pointer `sp` (0..DEPTH), the storage array `stk[0..DEPTH-1]`, and `stack_err`.
- Return address is `ra = pc + 1`, taken modulo 2^AW.
- Each edge, exactly one action is applied, chosen by this fixed priority:
  - `reset`: `pc`=0, `sp`=0, `stack_err`=0. Stack contents are don't-care.
  - `halt`: `pc`, `sp` and `stack_err` hold. Any `jmp`, `call` or `ret` in the same cycle is ignored.
  - `ret`:
    - if `sp`>0: `pc` <= `stk[sp-1]`, `sp` <= `sp`-1.
    - if `sp`=0 (underflow): `pc` <= `ra`, `sp` stays 0, `stack_err` <= 1.
  - `call`:
    - if `sp`<DEPTH: `stk[sp]` <= `ra`, `sp` <= `sp`+1, `pc` <= `target`.
    - if `sp`=DEPTH (overflow): `pc` <= `target`, no push, `sp` stays DEPTH, `stack_err` <= 1.
  - `jmp`: `pc` <= `target`. Stack unchanged.
  - none of the above: `pc` <= `ra`.
- Effective state machine: the block sits in one of EMPTY (`sp`=0), PARTIAL, or FULL (`sp`=DEPTH).
  - A push moves EMPTY→PARTIAL, or →FULL when DEPTH is reached.
  - A pop moves FULL→PARTIAL, or →EMPTY when `sp` reaches 0.
  - The only exit from any state via `reset` is to EMPTY.
- `stack_err` is cleared only by `reset`. Later valid operations do not clear it.
- Sequential PC wraps from 2^AW−1 to 0 with no flag. `ra` wraps the same way, so a `call` at address 2^AW−1 pushes 0.
- Flags are decoded combinationally from registered `sp`:
  - `stack_empty` = (`sp`==0)
  - `stack_full` = (`sp`==DEPTH)
  - `depth` = `sp`

## Timing
- All outputs change only after a `clk` rising edge. There are no combinational paths from inputs to outputs.
- Latency of any control input to `pc` is 1 cycle: inputs sampled at edge N appear on `pc` after edge N.
- Reset values, visible after the first edge with `reset`=1:
  - `pc`=0
  - `stack_empty`=1
  - `stack_full`=0
  - `stack_err`=0
  - `depth`=0
- Reset asserted mid-subroutine discards all stack entries in that same edge.
- After `reset` deasserts, the first edge with no control input yields `pc`=1.
- The stack read for `ret` uses the pre-edge `sp`. The return value is valid the cycle immediately after a `call`, with no forwarding hazard.
- `pc` must be stable for a full period so the instruction memory and the single-cycle datapath settle before the next edge. There is exactly one instruction per cycle.

## Test plan
- Reset, then 5 idle cycles → `pc` steps 0→1→2→3→4→5. Then `reset`=1 for one edge → `pc`=0, `depth`=0, `stack_empty`=1.
- At `pc`=3, assert `call`, `target`=0x040 → `pc`=0x040, `depth`=1, `stk[0]`=4. Two idle cycles → 0x041, 0x042. Then `ret` → `pc`=4, `depth`=0, `stack_err`=0.
- Nested calls with DEPTH=8 → `depth` reaches 8 and `stack_full`=1. A 9th `call` with `target`=0x100 → `pc`=0x100, `depth`=8, `stack_err`=1. Then 8 `ret` operations return the 8 pushed addresses in LIFO order.
- `ret` with empty stack at `pc`=0x010 → `pc`=0x011, `stack_err`=1, `depth`=0. `stack_err` stays 1 through later valid call/ret pairs until `reset`.
- `halt`=1 together with `call`, `target`=0x200, at `pc`=7 → `pc` stays 7 and `depth` is unchanged. Asserting `jmp` and `ret` together with a non-empty stack → the pop wins and `pc` takes the stack value.
- `jmp` to `target`=0x3FF, then idle → `pc`=0x000 (wrap). `call` at `pc`=0x3FF → pushes 0, and a later `ret` returns `pc`=0.
